cim_mem_scheduler: RTL

- Sequences the two read-modify-write accumulation lanes (lane 1 → CIM_1, lane 2 → CIM_2) against the output tile memory, and shares that memory with the off-chip scan port.
- Accepts PE tile requests via valid/ready, issues the memory read, strobes data-valid to the CIM, then issues the write-back.
- Blocks same-address hazards between lanes and drains both lanes before any scan access.

---
 rtl/cim_sched_pkg.sv | 29 ++
 rtl/cim_mem_scheduler_lane.sv | 89 ++++++++
 rtl/cim_mem_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cim_sched_pkg.sv
// Shared types and constants for the CIM output-memory scheduler.
//   lane_state_e : per-lane read-modify-write sequence
//   scan_state_e : off-chip scan port access sequence
//   SCAN_*       : scan_mode_i encodings (2'b11 is reserved and treated as a nop)
package cim_sched_pkg;

    localparam int NUM_LANES = 2;

    localparam logic [1:0] SCAN_NOP = 2'b00;
    localparam logic [1:0] SCAN_WR  = 2'b01;
    localparam logic [1:0] SCAN_RD  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        WB
    } lane_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_WR,
        S_RD,
        S_RWAIT,
        S_ACK
    } scan_state_e;

endpackage

// File: rtl/cim_mem_scheduler_lane.sv
// One read-modify-write accumulation lane.
// Sequence: IDLE -> READ (rd_en) -> WAIT (RD_LAT-1 cycles) -> WB (wr_en, dvalid) -> IDLE.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   accept           request handshake completed this cycle (only honoured in IDLE)
//   addr_in, od_in   request address / output-depth tag
//   idle             lane is in IDLE
//   addr, od         latched request address / tag
//   rd_en            memory read strobe (READ cycle)
//   wr_en, dvalid    write-back strobe and CIM data-valid (WB cycle)
module cim_lane_fsm
    import cim_sched_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int OD_W   = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [OD_W-1:0]   od_in,
    output logic              idle,
    output logic [ADDR_W-1:0] addr,
    output logic [OD_W-1:0]   od,
    output logic              rd_en,
    output logic              wr_en,
    output logic              dvalid
);

    // WAIT lasts RD_LAT-1 cycles; the counter is loaded on the READ->WAIT step.
    localparam logic [3:0] WAIT_INIT = (RD_LAT > 1) ? 4'(RD_LAT - 2) : 4'd0;

    lane_state_e state;
    logic [3:0]  wait_cnt;

    // NOTE: state and registered outputs use non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            addr     <= '0;
            od       <= '0;
            rd_en    <= 1'b0;
            wr_en    <= 1'b0;
            dvalid   <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-asserted below.
            rd_en  <= 1'b0;
            wr_en  <= 1'b0;
            dvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= READ;
                        addr  <= addr_in;
                        od    <= od_in;
                        rd_en <= 1'b1;
                    end
                end
                READ: begin
                    if (RD_LAT == 1) begin
                        state  <= WB;
                        wr_en  <= 1'b1;
                        dvalid <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state  <= WB;
                        wr_en  <= 1'b1;
                        dvalid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign idle = (state == IDLE);

endmodule

// File: rtl/cim_mem_scheduler.sv
// Output-tile memory scheduler for two CIM accumulation lanes plus the scan port.
// Lane k (bit k) runs read -> CIM -> write-back on the shared memory; same-address
// requests across lanes are serialised, and scan accesses wait for both lanes to drain.
// Ports:
//   pe_valid_i/pe_ready_o/pe_addr_i/pe_od_i   per-lane PE request handshake
//   mem_rd_en_o/mem_rd_addr_o                 per-lane memory read
//   mem_wr_en_o/mem_wr_addr_o/mem_dvalid_o    per-lane write-back and CIM data-valid
//   cim_od_o                                  latched od tag per lane
//   scan_req_i/scan_mode_i/scan_addr_i        scan request (held until scan_ack_o)
//   scan_ack_o/scan_rdata_valid_o             completion pulse / read data valid
//   scan_wr_en_o/scan_rd_en_o/scan_addr_o     scan memory strobes and address
//   busy_o                                    any lane or the scan FSM active
//   stall_cnt_o                               saturating count of hazard refusals
module cim_mem_scheduler
    import cim_sched_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int OD_W    = 8,
    parameter int RD_LAT  = 2,
    parameter int STALL_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_LANES-1:0]        pe_valid_i,
    output logic [NUM_LANES-1:0]        pe_ready_o,
    input  logic [NUM_LANES*ADDR_W-1:0] pe_addr_i,
    input  logic [NUM_LANES*OD_W-1:0]   pe_od_i,
    output logic [NUM_LANES-1:0]        mem_rd_en_o,
    output logic [NUM_LANES*ADDR_W-1:0] mem_rd_addr_o,
    output logic [NUM_LANES-1:0]        mem_wr_en_o,
    output logic [NUM_LANES*ADDR_W-1:0] mem_wr_addr_o,
    output logic [NUM_LANES-1:0]        mem_dvalid_o,
    output logic [NUM_LANES*OD_W-1:0]   cim_od_o,
    input  logic                        scan_req_i,
    input  logic [1:0]                  scan_mode_i,
    input  logic [ADDR_W-1:0]           scan_addr_i,
    output logic                        scan_ack_o,
    output logic                        scan_wr_en_o,
    output logic                        scan_rd_en_o,
    output logic [ADDR_W-1:0]           scan_addr_o,
    output logic                        scan_rdata_valid_o,
    output logic                        busy_o,
    output logic [STALL_W-1:0]          stall_cnt_o
);

    // S_RWAIT lasts RD_LAT cycles after the S_RD strobe.
    localparam logic [3:0] RWAIT_INIT = 4'(RD_LAT - 1);

    logic [NUM_LANES-1:0] lane_idle;
    logic [NUM_LANES-1:0] accept;
    logic [NUM_LANES-1:0] hazard;
    logic [NUM_LANES-1:0] tie_loss;
    logic [NUM_LANES-1:0] stall_evt;
    logic [ADDR_W-1:0]    lane_addr [NUM_LANES];

    scan_state_e scan_state;
    logic [1:0]  scan_mode;
    logic [3:0]  rwait_cnt;
    logic        scan_idle;
    logic        tie;
    logic        rr_ptr;        // 0: lane 1 wins the next tie, 1: lane 2

    // ------------------------------------------------------------------
    // Lanes
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        cim_lane_fsm #(
            .ADDR_W (ADDR_W),
            .OD_W   (OD_W),
            .RD_LAT (RD_LAT)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .accept  (accept[k]),
            .addr_in (pe_addr_i[k*ADDR_W +: ADDR_W]),
            .od_in   (pe_od_i[k*OD_W +: OD_W]),
            .idle    (lane_idle[k]),
            .addr    (lane_addr[k]),
            .od      (cim_od_o[k*OD_W +: OD_W]),
            .rd_en   (mem_rd_en_o[k]),
            .wr_en   (mem_wr_en_o[k]),
            .dvalid  (mem_dvalid_o[k])
        );

        // The CIM is combinational, so read and write-back use the same address.
        assign mem_rd_addr_o[k*ADDR_W +: ADDR_W] = lane_addr[k];
        assign mem_wr_addr_o[k*ADDR_W +: ADDR_W] = lane_addr[k];
    end

    // ------------------------------------------------------------------
    // Arbitration and hazard blocking
    // ------------------------------------------------------------------
    assign scan_idle = (scan_state == S_IDLE);

    // Both lanes free and asking for the same tile: only one may go.
    assign tie = &lane_idle & &pe_valid_i &
                 (pe_addr_i[0 +: ADDR_W] == pe_addr_i[ADDR_W +: ADDR_W]);

    // NOTE: every signal driven here gets a default before the loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        hazard     = '0;
        tie_loss   = '0;
        pe_ready_o = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            hazard[k]     = !lane_idle[1-k] &&
                            (lane_addr[1-k] == pe_addr_i[k*ADDR_W +: ADDR_W]);
            tie_loss[k]   = tie && (rr_ptr != 1'(k));
            // scan_req_i blocks in the same cycle so a rising request always wins.
            pe_ready_o[k] = lane_idle[k] && scan_idle && !scan_req_i &&
                            !hazard[k] && !tie_loss[k];
        end
    end

    assign accept    = pe_valid_i & pe_ready_o;
    assign stall_evt = pe_valid_i & (hazard | tie_loss);

    // The pointer only moves when a tie is actually granted, handing the next
    // tie to the lane that just lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (tie && accept[rr_ptr]) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // ------------------------------------------------------------------
    // Stall counter: up to +2 per cycle, saturating at all-ones
    // ------------------------------------------------------------------
    logic [1:0]       stall_inc;
    logic [STALL_W:0] stall_sum;

    assign stall_inc = {1'b0, stall_evt[0]} + {1'b0, stall_evt[1]};
    assign stall_sum = {1'b0, stall_cnt_o} + (STALL_W+1)'(stall_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= '0;
        end else if (stall_sum[STALL_W]) begin
            stall_cnt_o <= '1;
        end else begin
            stall_cnt_o <= stall_sum[STALL_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: drain lanes, perform one access, acknowledge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_state         <= S_IDLE;
            scan_mode          <= SCAN_NOP;
            scan_addr_o        <= '0;
            rwait_cnt          <= '0;
            scan_wr_en_o       <= 1'b0;
            scan_rd_en_o       <= 1'b0;
            scan_ack_o         <= 1'b0;
            scan_rdata_valid_o <= 1'b0;
        end else begin
            scan_wr_en_o       <= 1'b0;
            scan_rd_en_o       <= 1'b0;
            scan_ack_o         <= 1'b0;
            scan_rdata_valid_o <= 1'b0;
            case (scan_state)
                S_IDLE: begin
                    if (scan_req_i) begin
                        scan_state  <= S_DRAIN;
                        scan_mode   <= scan_mode_i;
                        scan_addr_o <= scan_addr_i;
                    end
                end
                S_DRAIN: begin
                    if (&lane_idle) begin
                        case (scan_mode)
                            SCAN_WR: begin
                                scan_state   <= S_WR;
                                scan_wr_en_o <= 1'b1;
                            end
                            SCAN_RD: begin
                                scan_state   <= S_RD;
                                scan_rd_en_o <= 1'b1;
                            end
                            default: begin   // nop and reserved mode
                                scan_state <= S_ACK;
                                scan_ack_o <= 1'b1;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    scan_state <= S_ACK;
                    scan_ack_o <= 1'b1;
                end
                S_RD: begin
                    scan_state <= S_RWAIT;
                    rwait_cnt  <= RWAIT_INIT;
                end
                S_RWAIT: begin
                    if (rwait_cnt == 4'd0) begin
                        scan_state         <= S_ACK;
                        scan_ack_o         <= 1'b1;
                        scan_rdata_valid_o <= 1'b1;
                    end else begin
                        rwait_cnt <= rwait_cnt - 4'd1;
                    end
                end
                S_ACK:   scan_state <= S_IDLE;
                default: scan_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o = !(&lane_idle) || !scan_idle;

endmodule
